cnn_conv_layer_sequencer: RTL

- Controller for cnn_conv_3x3_dilation_multi_channel_new: one start runs one complete convolution layer.
- Reads weights from an external weight RAM and pixels from an external feature-map RAM, and streams both into the conv engine with the engine's valid-qualified protocol.
- Counts engine outputs, then signals done.
- Sits between the layer scheduler (start/done) and one conv engine instance.

---
 rtl/cnn_pkg.sv | 25 ++
 rtl/cnn_rd_stage.sv | 27 ++
 rtl/cnn_conv_layer_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the conv-layer sequencer: state encoding and
// layer-size helpers derived from the layer parameters.
package cnn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    function automatic int weight_num(input int cin, input int cout, input int k);
        return cin * cout * k * k;
    endfunction

    function automatic int pixel_num(input int cin, input int w, input int h);
        return cin * w * h;
    endfunction

    function automatic int out_expect(input int cout, input int w, input int h, input logic stride2);
        return stride2 ? cout * (w / 2) * (h / 2) : cout * w * h;
    endfunction

endpackage

// File: rtl/cnn_rd_stage.sv
// One-cycle RAM-to-engine stage: the strobe is delayed to line up with the
// RAM's registered read data, and data is forced to zero when not valid.
module cnn_rd_stage #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rd_en_i,
    input  logic [DW-1:0] rd_data_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o
);

    logic valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= rd_en_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = valid_q ? rd_data_i : '0;

endmodule

// File: rtl/cnn_conv_layer_sequencer.sv
// Runs one convolution layer per start: streams all weights, then all pixels,
// into the conv engine, then waits for the expected number of engine outputs.
module cnn_conv_layer_sequencer
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int IMAGE_WIDTH     = 16,
    parameter int IMAGE_HEIGHT    = 16,
    parameter int CHANNEL_NUM_IN  = 64,
    parameter int CHANNEL_NUM_OUT = 2,
    parameter int KERNEL          = 3,
    parameter int DRAIN_TIMEOUT   = 4096,
    localparam int WA = $clog2(CHANNEL_NUM_IN * CHANNEL_NUM_OUT * KERNEL * KERNEL),
    localparam int IA = $clog2(CHANNEL_NUM_IN * IMAGE_WIDTH * IMAGE_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stride2_cfg,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  weight_rd_en,
    output logic [WA-1:0]         weight_rd_addr,
    input  logic [DATA_WIDTH-1:0] weight_rd_data,
    output logic                  img_rd_en,
    output logic [IA-1:0]         img_rd_addr,
    input  logic [DATA_WIDTH-1:0] img_rd_data,
    output logic                  eng_stride2,
    output logic                  eng_valid_weight_in,
    output logic [DATA_WIDTH-1:0] eng_weight_in,
    output logic                  eng_valid_in,
    output logic [DATA_WIDTH-1:0] eng_pxl_in,
    input  logic                  eng_valid_out,
    output logic [15:0]           out_count
);

    localparam int WEIGHT_NUM = weight_num(CHANNEL_NUM_IN, CHANNEL_NUM_OUT, KERNEL);
    localparam int PIXEL_NUM  = pixel_num(CHANNEL_NUM_IN, IMAGE_WIDTH, IMAGE_HEIGHT);
    localparam logic [15:0] EXPECT_S1 =
        16'(out_expect(CHANNEL_NUM_OUT, IMAGE_WIDTH, IMAGE_HEIGHT, 1'b0));
    localparam logic [15:0] EXPECT_S2 =
        16'(out_expect(CHANNEL_NUM_OUT, IMAGE_WIDTH, IMAGE_HEIGHT, 1'b1));
    localparam int TW = $clog2(DRAIN_TIMEOUT + 1);

    state_e        state_q, state_d;
    logic [WA-1:0] w_addr_q, w_addr_d;
    logic [IA-1:0] p_addr_q, p_addr_d;
    logic [15:0]   out_cnt_q, out_cnt_d;
    logic [TW-1:0] idle_q, idle_d;
    logic          stride2_q, stride2_d;
    logic          error_q, error_d;
    logic          w_rd_en, p_rd_en;
    logic [15:0]   out_target;

    assign out_target = stride2_q ? EXPECT_S2 : EXPECT_S1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            w_addr_q  <= '0;
            p_addr_q  <= '0;
            out_cnt_q <= '0;
            idle_q    <= '0;
            stride2_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            w_addr_q  <= w_addr_d;
            p_addr_q  <= p_addr_d;
            out_cnt_q <= out_cnt_d;
            idle_q    <= idle_d;
            stride2_q <= stride2_d;
            error_q   <= error_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        w_addr_d  = w_addr_q;
        p_addr_d  = p_addr_q;
        out_cnt_d = out_cnt_q;
        idle_d    = idle_q;
        stride2_d = stride2_q;
        error_d   = error_q;
        w_rd_en   = 1'b0;
        p_rd_en   = 1'b0;

        // Engine outputs only count while a layer is in flight; saturate at max.
        if (eng_valid_out && out_cnt_q != 16'hFFFF &&
            (state_q == ST_LOAD_W || state_q == ST_STREAM || state_q == ST_DRAIN)) begin
            out_cnt_d = out_cnt_q + 16'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_LOAD_W;
                    stride2_d = stride2_cfg;
                    error_d   = 1'b0;
                    out_cnt_d = '0;
                    w_addr_d  = '0;
                    p_addr_d  = '0;
                    idle_d    = '0;
                end
            end
            ST_LOAD_W: begin
                w_rd_en = 1'b1;
                if (w_addr_q == WA'(WEIGHT_NUM - 1)) begin
                    state_d = ST_STREAM;
                end else begin
                    w_addr_d = w_addr_q + WA'(1);
                end
            end
            ST_STREAM: begin
                p_rd_en = 1'b1;
                idle_d  = '0;
                if (p_addr_q == IA'(PIXEL_NUM - 1)) begin
                    state_d = ST_DRAIN;
                end else begin
                    p_addr_d = p_addr_q + IA'(1);
                end
            end
            ST_DRAIN: begin
                // idle_q counts consecutive DRAIN cycles already seen without an output.
                if (out_cnt_q >= out_target) begin
                    state_d = ST_DONE;
                end else if (eng_valid_out) begin
                    idle_d = '0;
                end else if (idle_q == TW'(DRAIN_TIMEOUT - 1)) begin
                    state_d = ST_DONE;
                    error_d = 1'b1;
                end else begin
                    idle_d = idle_q + TW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy           = (state_q != ST_IDLE);
    assign done           = (state_q == ST_DONE);
    assign error          = error_q;
    assign out_count      = out_cnt_q;
    assign eng_stride2    = stride2_q;
    assign weight_rd_en   = w_rd_en;
    assign weight_rd_addr = w_addr_q;
    assign img_rd_en      = p_rd_en;
    assign img_rd_addr    = p_addr_q;

    cnn_rd_stage #(.DW(DATA_WIDTH)) u_weight_stage (
        .clk      (clk),
        .reset    (reset),
        .rd_en_i  (w_rd_en),
        .rd_data_i(weight_rd_data),
        .valid_o  (eng_valid_weight_in),
        .data_o   (eng_weight_in)
    );

    cnn_rd_stage #(.DW(DATA_WIDTH)) u_pixel_stage (
        .clk      (clk),
        .reset    (reset),
        .rd_en_i  (p_rd_en),
        .rd_data_i(img_rd_data),
        .valid_o  (eng_valid_in),
        .data_o   (eng_pxl_in)
    );

endmodule
